// File: rtl/ptw_arb_pkg.sv
// ptw_arb_pkg: shared types and constants for the page-table-walk memory arbiter.
// Holds the FSM state encoding and the owner encoding used by the top and the picker.
package ptw_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage : ptw_arb_pkg

// File: rtl/ptw_arb_pick.sv
// ptw_arb_pick: combinational two-way picker between the IFU and LSU walkers.
// Build option PTW_ARB_RR_EN: round-robin on the last-grant pointer
// (the requester not granted last wins a tie). Without it, LSU has fixed
// priority over IFU and the pointer input does not exist.
module ptw_arb_pick
    import ptw_arb_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
`ifdef PTW_ARB_RR_EN
    input  logic last_grant,
`endif
    output logic gnt_valid,
    output logic winner
);

    // Grant whenever either side asks; resolve ties according to the build option.
    always_comb begin
        gnt_valid = if_req | ls_req;
        winner    = OWN_IF;
`ifdef PTW_ARB_RR_EN
        if (if_req && ls_req) begin
            winner = (last_grant == OWN_LS) ? OWN_IF : OWN_LS;
        end else if (ls_req) begin
            winner = OWN_LS;
        end else begin
            winner = OWN_IF;
        end
`else
        if (ls_req) begin
            winner = OWN_LS;
        end else begin
            winner = OWN_IF;
        end
`endif
    end

endmodule : ptw_arb_pick

// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: shares one PTW memory read port between the IFU and LSU MMUs.
// One transaction is outstanding at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// A flush from the owner while the read is in flight lets the memory read
// finish but suppresses the response pulse.
// Build option PTW_ARB_RR_EN selects round-robin arbitration (default: LSU first).
module ptw_mem_arbiter
    import ptw_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_rvalid_o,
    input  logic              ls_req_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic              ls_flush_i,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_rvalid_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              busy_o,
    output logic              owner_o
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_e        state_r;
    arb_state_e        state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] rdata_r;
    logic              owner_r;
    logic              drop_r;
    logic              gnt_valid_s;
    logic              winner_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              owner_flush_s;
    logic              grant_s;
    logic              deliver_s;

`ifdef PTW_ARB_RR_EN
    logic              last_grant_r;
`endif

    ptw_arb_pick u_pick (
        .if_req     (if_req_i),
        .ls_req     (ls_req_i),
`ifdef PTW_ARB_RR_EN
        .last_grant (last_grant_r),
`endif
        .gnt_valid  (gnt_valid_s),
        .winner     (winner_s)
    );

    // Grant qualification, winner address select and owner flush select.
    always_comb begin
        grant_s       = (state_r == IDLE) && gnt_valid_s;
        sel_addr_s    = (winner_s == OWN_LS) ? ls_addr_i : if_addr_i;
        owner_flush_s = (owner_r == OWN_LS) ? ls_flush_i : if_flush_i;
        deliver_s     = (state_r == RESP) && !drop_r;
    end

    // Next-state logic for the single-outstanding read sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) state_s = ISSUE;
                else             state_s = IDLE;
            end
            ISSUE: begin
                if (mem_ready_i) state_s = WAIT;
                else             state_s = ISSUE;
            end
            WAIT: begin
                if (mem_rvalid_i) state_s = RESP;
                else              state_s = WAIT;
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the winner's word-aligned address and identity at grant only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= {ADDR_W{1'b0}};
            owner_r <= OWN_IF;
        end else if (grant_s) begin
            addr_r  <= sel_addr_s & WORD_MASK;
            owner_r <= winner_s;
        end else begin
            addr_r  <= addr_r;
            owner_r <= owner_r;
        end
    end

    // Drop flag: set by an owner flush while in flight, cleared on return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_r <= 1'b0;
        end else if (state_s == IDLE) begin
            drop_r <= 1'b0;
        end else if (((state_r == ISSUE) || (state_r == WAIT)) && owner_flush_s) begin
            drop_r <= 1'b1;
        end else begin
            drop_r <= drop_r;
        end
    end

    // Capture read data only while waiting; stray rvalid elsewhere is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if ((state_r == WAIT) && mem_rvalid_i) begin
            rdata_r <= mem_rdata_i;
        end else begin
            rdata_r <= rdata_r;
        end
    end

`ifdef PTW_ARB_RR_EN
    // Last-grant pointer, updated at every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= OWN_IF;
        end else if (grant_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Outputs decoded from registered state; data is only presented with its pulse.
    always_comb begin
        mem_req_o   = (state_r == ISSUE);
        mem_addr_o  = addr_r;
        busy_o      = (state_r != IDLE);
        owner_o     = owner_r;
        if_rvalid_o = deliver_s && (owner_r == OWN_IF);
        ls_rvalid_o = deliver_s && (owner_r == OWN_LS);
        if_rdata_o  = if_rvalid_o ? rdata_r : {DATA_W{1'b0}};
        ls_rdata_o  = ls_rvalid_o ? rdata_r : {DATA_W{1'b0}};
    end

endmodule : ptw_mem_arbiter

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter: directed, table-driven bench for the PTW memory arbiter,
// plus hand-written flush and asynchronous-reset sequences.
module tb_ptw_mem_arbiter;
    import ptw_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        if_req_i, ls_req_i;
    logic [31:0] if_addr_i, ls_addr_i;
    logic        if_flush_i, ls_flush_i;
    logic [31:0] if_rdata_o, ls_rdata_o;
    logic        if_rvalid_o, ls_rvalid_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic        mem_rvalid_i;
    logic        busy_o, owner_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        if_req;
        logic        ls_req;
        logic [31:0] if_addr;
        logic [31:0] ls_addr;
        int          rdy_dly;
        int          rv_dly;
        logic [31:0] rdata;
        logic        exp_owner;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [5];

    ptw_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_flush_i   (if_flush_i),
        .if_rdata_o   (if_rdata_o),
        .if_rvalid_o  (if_rvalid_o),
        .ls_req_i     (ls_req_i),
        .ls_addr_i    (ls_addr_i),
        .ls_flush_i   (ls_flush_i),
        .ls_rdata_o   (ls_rdata_o),
        .ls_rvalid_o  (ls_rvalid_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i),
        .busy_o       (busy_o),
        .owner_o      (owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_if_rvalid"}, if_rvalid_o, 1'b0);
        chk1({tag, "_ls_rvalid"}, ls_rvalid_o, 1'b0);
    endtask

    // One complete walk from IDLE; addresses are scrambled after grant.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        if_req_i  = v.if_req;
        ls_req_i  = v.ls_req;
        if_addr_i = v.if_addr;
        ls_addr_i = v.ls_addr;
        step();
        chk1 ({tag, "_issue_req"},   mem_req_o,  1'b1);
        chk32({tag, "_issue_addr"},  mem_addr_o, v.exp_addr);
        chk1 ({tag, "_issue_owner"}, owner_o,    v.exp_owner);
        chk1 ({tag, "_issue_busy"},  busy_o,     1'b1);
        if_addr_i = ~v.if_addr;
        ls_addr_i = ~v.ls_addr;
        for (int i = 0; i < v.rdy_dly; i++) begin
            step();
            chk1 ({tag, "_bp_req"},  mem_req_o,  1'b1);
            chk32({tag, "_bp_addr"}, mem_addr_o, v.exp_addr);
        end
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        chk1({tag, "_wait_req"},  mem_req_o, 1'b0);
        chk1({tag, "_wait_busy"}, busy_o,    1'b1);
        for (int i = 0; i < v.rv_dly; i++) begin
            step();
            chk_quiet({tag, "_wait"});
            chk1({tag, "_wait_busy2"}, busy_o, 1'b1);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = v.rdata;
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hFFFF_0000;
        chk1({tag, "_resp_if_rvalid"}, if_rvalid_o, v.exp_owner == OWN_IF);
        chk1({tag, "_resp_ls_rvalid"}, ls_rvalid_o, v.exp_owner == OWN_LS);
        if (v.exp_owner == OWN_IF) chk32({tag, "_resp_if_rdata"}, if_rdata_o, v.rdata);
        else                       chk32({tag, "_resp_ls_rdata"}, ls_rdata_o, v.rdata);
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        step();
        chk1({tag, "_idle_busy"}, busy_o, 1'b0);
        chk_quiet({tag, "_idle"});
    endtask

    initial begin
        rst_n        = 1'b0;
        if_req_i     = 1'b0;
        ls_req_i     = 1'b0;
        if_addr_i    = 32'h0;
        ls_addr_i    = 32'h0;
        if_flush_i   = 1'b0;
        ls_flush_i   = 1'b0;
        mem_ready_i  = 1'b0;
        mem_rdata_i  = 32'h0;
        mem_rvalid_i = 1'b0;

        //          if   ls   if_addr        ls_addr        rdy rv  rdata          owner   exp_addr
        vecs[0] = '{1'b1, 1'b0, 32'h8000_1007, 32'h0000_0000, 0, 1, 32'h2000_00CF, OWN_IF, 32'h8000_1004};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_2002, 0, 0, 32'h1111_0001, OWN_LS, 32'h0000_2000};
`ifdef PTW_ARB_RR_EN
        vecs[2] = '{1'b1, 1'b1, 32'h0000_3003, 32'h0000_4000, 1, 3, 32'hAAAA_5555, OWN_IF, 32'h0000_3000};
`else
        vecs[2] = '{1'b1, 1'b1, 32'h0000_3003, 32'h0000_4000, 1, 3, 32'hAAAA_5555, OWN_LS, 32'h0000_4000};
`endif
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 5, 0, 32'h5555_AAAA, OWN_LS, 32'hFFFF_FFFC};
        vecs[4] = '{1'b1, 1'b0, 32'h1234_5679, 32'h0000_0000, 0, 0, 32'h0000_0000, OWN_IF, 32'h1234_5678};

        // Reset values while held in reset.
        step();
        chk1 ("rst_busy",      busy_o,      1'b0);
        chk1 ("rst_mem_req",   mem_req_o,   1'b0);
        chk32("rst_mem_addr",  mem_addr_o,  32'h0);
        chk1 ("rst_owner",     owner_o,     1'b0);
        chk1 ("rst_if_rvalid", if_rvalid_o, 1'b0);
        chk1 ("rst_ls_rvalid", ls_rvalid_o, 1'b0);
        chk32("rst_if_rdata",  if_rdata_o,  32'h0);
        chk32("rst_ls_rdata",  ls_rdata_o,  32'h0);
        rst_n = 1'b1;
        step();
        chk1("idle_busy", busy_o, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // Flush of the owner in WAIT: response consumed, no pulse, pending IFU next.
        ls_req_i  = 1'b1;
        ls_addr_i = 32'h0000_5008;
        step();
        chk1 ("fl_owner", owner_o,    OWN_LS);
        chk32("fl_addr",  mem_addr_o, 32'h0000_5008);
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_6012;
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        ls_flush_i = 1'b1;
        step();
        ls_flush_i = 1'b0;
        ls_req_i   = 1'b0;
        chk1("fl_wait_busy", busy_o,    1'b1);
        chk1("fl_wait_req",  mem_req_o, 1'b0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        step();
        mem_rvalid_i = 1'b0;
        chk_quiet("fl_resp");
        chk1("fl_resp_busy", busy_o, 1'b1);
        if_flush_i = 1'b1;
        step();
        if_flush_i = 1'b0;
        chk1("fl_idle_busy", busy_o, 1'b0);
        chk_quiet("fl_idle");
        step();
        chk1 ("fl2_req",   mem_req_o,  1'b1);
        chk1 ("fl2_owner", owner_o,    OWN_IF);
        chk32("fl2_addr",  mem_addr_o, 32'h0000_6010);
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        ls_flush_i = 1'b1;
        step();
        ls_flush_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BAD_F00D;
        step();
        mem_rvalid_i = 1'b0;
        chk1 ("fl2_if_rvalid", if_rvalid_o, 1'b1);
        chk32("fl2_if_rdata",  if_rdata_o,  32'h0BAD_F00D);
        chk1 ("fl2_ls_rvalid", ls_rvalid_o, 1'b0);
        if_req_i = 1'b0;
        step();
        chk1("fl2_idle_busy", busy_o, 1'b0);

        // Asynchronous reset in WAIT, then a stray rvalid after release.
        ls_req_i  = 1'b1;
        ls_addr_i = 32'h0000_7000;
        step();
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        chk1 ("ar_pre_busy",  busy_o,     1'b1);
        chk1 ("ar_pre_owner", owner_o,    OWN_LS);
        chk32("ar_pre_addr",  mem_addr_o, 32'h0000_7000);
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("ar_busy",      busy_o,      1'b0);
        chk1 ("ar_mem_req",   mem_req_o,   1'b0);
        chk32("ar_mem_addr",  mem_addr_o,  32'h0);
        chk1 ("ar_owner",     owner_o,     1'b0);
        chk_quiet("ar");
        chk32("ar_if_rdata",  if_rdata_o,  32'h0);
        chk32("ar_ls_rdata",  ls_rdata_o,  32'h0);
        ls_req_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        step();
        mem_rvalid_i = 1'b0;
        chk_quiet("ar_stray");
        chk1("ar_stray_busy", busy_o, 1'b0);
        step();
        chk_quiet("ar_stray2");
        chk1("ar_stray2_busy", busy_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_ptw_mem_arbiter
